// File: rtl/ftrace_pkg.sv
// ftrace_pkg: shared constants and the queued event record for the
// function-trace collector.
//   OPC_JAL / OPC_JALR : RV32 opcodes of the two jump instructions
//   INST_RET           : canonical return, jalr x0, 0(x1)
//   ftrace_evt_t       : one queued trace event
package ftrace_pkg;

    localparam logic [6:0]  OPC_JAL  = 7'b1101111;
    localparam logic [6:0]  OPC_JALR = 7'b1100111;
    localparam logic [31:0] INST_RET = 32'h0000_8067;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nextpc;
        logic        is_jal;
        logic        is_ret;
        logic        is_rd0;
    } ftrace_evt_t;

endpackage

// File: rtl/ftrace_collector_if.sv
// ftrace_collector_if: commit-side inputs, sink handshake and status of the
// function-trace collector.
//   master : driver of commits and of out_ready (commit stage / sink side)
//   slave  : the collector
interface ftrace_collector_if #(
    parameter int DEPTH_W = 8,
    parameter int DROP_W  = 16
);
    logic               commit_valid;
    logic [31:0]        commit_pc;
    logic [31:0]        commit_nextpc;
    logic [31:0]        commit_inst;
    logic               trace_en;
    logic               out_ready;

    logic               dpi_valid;
    logic               func_flag;
    logic               is_jal;
    logic               is_ret;
    logic               is_rd0;
    logic [31:0]        pc;
    logic [31:0]        nextpc;
    logic [DEPTH_W-1:0] call_depth;
    logic               depth_err;
    logic               fifo_full;
    logic [DROP_W-1:0]  drop_cnt;

    modport master (
        output commit_valid, commit_pc, commit_nextpc, commit_inst, trace_en, out_ready,
        input  dpi_valid, func_flag, is_jal, is_ret, is_rd0, pc, nextpc,
               call_depth, depth_err, fifo_full, drop_cnt
    );

    modport slave (
        input  commit_valid, commit_pc, commit_nextpc, commit_inst, trace_en, out_ready,
        output dpi_valid, func_flag, is_jal, is_ret, is_rd0, pc, nextpc,
               call_depth, depth_err, fifo_full, drop_cnt
    );
endinterface

// File: rtl/ftrace_fifo.sv
// ftrace_fifo: generic synchronous FIFO, head word read straight from storage.
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write wdata_i (caller guarantees room, or a same-cycle pop)
//   pop_i      : drop the head (caller guarantees non-empty)
//   rdata_o    : head entry
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
module ftrace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    // When full with a pop, wr_q == rd_q: the head is read this cycle and
    // overwritten at the edge, which is exactly the wanted behaviour.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ftrace_collector.sv
// ftrace_collector: classifies retired JAL/JALR instructions, queues them and
// hands them to the function-trace sink one per cycle.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : commit inputs, sink valid/ready and status (slave side)
module ftrace_collector
    import ftrace_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DEPTH_W    = 8,
    parameter int DROP_W     = 16
) (
    input  logic                clock,
    input  logic                reset,
    ftrace_collector_if.slave   bus
);
    logic        is_jal_c, is_jalr_c, jmp_c, rd0_c, ret_c, call_c;
    logic        cand, push, pop, drop, full, empty;
    ftrace_evt_t wevt, head, evt_out;

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    ftrace_evt_t        last_q, last_d;
    logic               func_q, func_d;

    always_comb begin
        is_jal_c  = (bus.commit_inst[6:0] == OPC_JAL);
        is_jalr_c = (bus.commit_inst[6:0] == OPC_JALR) && (bus.commit_inst[14:12] == 3'd0);
        jmp_c     = is_jal_c | is_jalr_c;
        rd0_c     = (bus.commit_inst[11:7] == 5'd0);
        ret_c     = (bus.commit_inst == INST_RET);
        call_c    = jmp_c & ~rd0_c;
    end

    assign cand = bus.commit_valid & bus.trace_en & jmp_c;
    assign pop  = ~empty & bus.out_ready;
    assign push = cand & (~full | pop);
    assign drop = cand & full & ~pop;

    always_comb begin
        wevt        = '0;
        wevt.pc     = bus.commit_pc;
        wevt.nextpc = bus.commit_nextpc;
        wevt.is_jal = is_jal_c;
        wevt.is_ret = ret_c;
        wevt.is_rd0 = rd0_c;
    end

    ftrace_fifo #(
        .WIDTH ($bits(ftrace_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wevt),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Depth only moves on accepted events; a saturating move still queues
    // the event but latches the error.
    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        drop_d  = drop_q;
        last_d  = last_q;
        func_d  = func_q;
        if (push) begin
            if (call_c) begin
                if (depth_q == '1) err_d = 1'b1;
                else               depth_d = depth_q + 1'b1;
            end else if (ret_c) begin
                if (depth_q == '0) err_d = 1'b1;
                else               depth_d = depth_q - 1'b1;
            end
        end
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
        // Keep a copy of the last event handed over so the outputs hold
        // steady once the FIFO runs empty.
        if (pop) begin
            last_d = head;
            func_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
            last_q  <= '0;
            func_q  <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            last_q  <= last_d;
            func_q  <= func_d;
        end
    end

    assign evt_out        = empty ? last_q : head;
    assign bus.dpi_valid  = ~empty;
    assign bus.func_flag  = ~empty | func_q;
    assign bus.is_jal     = evt_out.is_jal;
    assign bus.is_ret     = evt_out.is_ret;
    assign bus.is_rd0     = evt_out.is_rd0;
    assign bus.pc         = evt_out.pc;
    assign bus.nextpc     = evt_out.nextpc;
    assign bus.call_depth = depth_q;
    assign bus.depth_err  = err_q;
    assign bus.fifo_full  = full;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_ftrace_collector.sv
// tb_ftrace_collector: table vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_ftrace_collector;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftrace_collector_if #(.DEPTH_W(8), .DROP_W(16)) bus ();

    ftrace_collector #(
        .FIFO_DEPTH (DEPTH),
        .DEPTH_W    (8),
        .DROP_W     (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] nextpc;
        logic        jal;
        logic        ret;
        logic        rd0;
    } mev_t;

    mev_t q[$];
    mev_t m_last;
    bit   m_func;
    int   m_depth;
    bit   m_err;
    int   m_drop;

    task automatic model_reset();
        q.delete();
        m_last  = '{pc: 32'h0, nextpc: 32'h0, jal: 1'b0, ret: 1'b0, rd0: 1'b0};
        m_func  = 0;
        m_depth = 0;
        m_err   = 0;
        m_drop  = 0;
    endtask

    task automatic model_step(input logic cv, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] npc, input logic en, input logic rdy);
        bit   j, jr, rd0, ret, popped, cand, room;
        mev_t e;
        j      = (inst[6:0] == 7'h6F);
        jr     = (inst[6:0] == 7'h67) && (inst[14:12] == 3'd0);
        rd0    = (inst[11:7] == 5'd0);
        ret    = (inst == 32'h0000_8067);
        popped = (q.size() != 0) && rdy;
        cand   = cv && en && (j || jr);
        room   = (q.size() < DEPTH);
        if (popped) begin
            m_last = q.pop_front();
            m_func = 1;
        end
        if (cand) begin
            if (room || popped) begin
                e = '{pc: pc, nextpc: npc, jal: j, ret: ret, rd0: rd0};
                q.push_back(e);
                if (!rd0) begin
                    if (m_depth == 255) m_err = 1; else m_depth++;
                end else if (ret) begin
                    if (m_depth == 0) m_err = 1; else m_depth--;
                end
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
    endtask

    function automatic logic [94:0] exp_obs();
        mev_t h;
        logic v;
        v = (q.size() != 0);
        h = v ? q[0] : m_last;
        return {v, v | m_func, h.jal, h.ret, h.rd0, h.pc, h.nextpc,
                8'(m_depth), m_err, q.size() == DEPTH, 16'(m_drop)};
    endfunction

    function automatic logic [94:0] got_obs();
        return {bus.dpi_valid, bus.func_flag, bus.is_jal, bus.is_ret, bus.is_rd0,
                bus.pc, bus.nextpc, bus.call_depth, bus.depth_err, bus.fifo_full, bus.drop_cnt};
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Apply one cycle of inputs (from a negedge) and advance the model.
    task automatic drive(input logic cv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] npc, input logic en, input logic rdy);
        bus.commit_valid  = cv;
        bus.commit_inst   = inst;
        bus.commit_pc     = pc;
        bus.commit_nextpc = npc;
        bus.trace_en      = en;
        bus.out_ready     = rdy;
        model_step(cv, inst, pc, npc, en, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.commit_valid = 1'b0; bus.commit_inst = '0; bus.commit_pc = '0;
        bus.commit_nextpc = '0; bus.trace_en = 1'b1; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        cv;
        logic [31:0] inst, pc, npc;
        logic        en, rdy;
        logic        e_valid, e_jal, e_ret, e_rd0;
        logic [31:0] e_pc;
        logic [7:0]  e_depth;
        logic        e_err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] r, inst;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          pct;

        tbl[0] = '{1'b1, 32'h008000EF, 32'h80000000, 32'h80000008, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000, 8'd1, 1'b0};
        tbl[1] = '{1'b1, 32'h00008067, 32'h80000100, 32'h80000004, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80000100, 8'd0, 1'b0};
        tbl[2] = '{1'b1, 32'h00100093, 32'h80000104, 32'h80000108, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000100, 8'd0, 1'b0};
        tbl[3] = '{1'b1, 32'h008000EF, 32'h80000108, 32'h80000110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000100, 8'd0, 1'b0};
        tbl[4] = '{1'b0, 32'h008000EF, 32'h8000010C, 32'h80000114, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000100, 8'd0, 1'b0};
        tbl[5] = '{1'b1, 32'h00009067, 32'h80000110, 32'h80000200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000100, 8'd0, 1'b0};
        tbl[6] = '{1'b1, 32'h000082E7, 32'h80000114, 32'h80000300, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000114, 8'd1, 1'b0};
        tbl[7] = '{1'b1, 32'h0080006F, 32'h80000300, 32'h80000308, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80000300, 8'd1, 1'b0};
        tbl[8] = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80000300, 8'd1, 1'b0};

        do_reset();
        check("reset_state", 128'(got_obs()), 128'(95'h0));

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].cv, tbl[i].inst, tbl[i].pc, tbl[i].npc, tbl[i].en, tbl[i].rdy);
            check($sformatf("table[%0d]", i),
                  128'({bus.dpi_valid, bus.is_jal, bus.is_ret, bus.is_rd0, bus.pc,
                        bus.call_depth, bus.depth_err, bus.fifo_full, bus.drop_cnt}),
                  128'({tbl[i].e_valid, tbl[i].e_jal, tbl[i].e_ret, tbl[i].e_rd0, tbl[i].e_pc,
                        tbl[i].e_depth, tbl[i].e_err, 1'b0, 16'd0}));
        end

        // Overflow: 10 calls into an 8-deep FIFO with the sink stalled.
        do_reset();
        for (int i = 0; i < 10; i++)
            drive(1'b1, 32'h008000EF, 32'h100 + 32'(4*i), 32'h1000, 1'b1, 1'b0);
        check("ovf_state", 128'({bus.dpi_valid, bus.fifo_full, bus.drop_cnt, bus.call_depth, bus.pc}),
              128'({1'b1, 1'b1, 16'd2, 8'd8, 32'h100}));
        // Full FIFO, pop and push in the same cycle: push accepted.
        drive(1'b1, 32'h008000EF, 32'h200, 32'h2000, 1'b1, 1'b1);
        check("full_pop_push", 128'({bus.dpi_valid, bus.fifo_full, bus.drop_cnt, bus.call_depth, bus.pc}),
              128'({1'b1, 1'b1, 16'd2, 8'd9, 32'h104}));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain[%0d]", i), 128'({bus.dpi_valid, bus.pc}),
                  128'({1'b1, (i < 7) ? 32'h104 + 32'(4*i) : 32'h200}));
            idle(1'b1);
        end
        check("drain_empty", 128'({bus.dpi_valid, bus.fifo_full, bus.drop_cnt}), 128'({1'b0, 1'b0, 16'd2}));

        // Return at depth 0: event queued, depth held, sticky error.
        do_reset();
        drive(1'b1, 32'h00008067, 32'h300, 32'h304, 1'b1, 1'b1);
        check("underflow", 128'({bus.dpi_valid, bus.is_ret, bus.call_depth, bus.depth_err}),
              128'({1'b1, 1'b1, 8'd0, 1'b1}));
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check($sformatf("err_sticky[%0d]", i), 128'({bus.dpi_valid, bus.call_depth, bus.depth_err}),
                  128'({1'b0, 8'd0, 1'b1}));
        end

        // Asynchronous reset with three events queued and the sink stalled.
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h008000EF, 32'h400 + 32'(4*i), 32'h4000, 1'b1, 1'b0);
        check("pre_reset", 128'({bus.dpi_valid, bus.fifo_full, bus.call_depth}), 128'({1'b1, 1'b0, 8'd3}));
        #3 rst = 1'b1;
        bus.commit_valid = 1'b0;
        #1;
        check("async_reset", 128'({bus.dpi_valid, bus.fifo_full, bus.call_depth, bus.drop_cnt, bus.depth_err}),
              128'({1'b0, 1'b0, 8'd0, 16'd0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check($sformatf("no_stale[%0d]", i), 128'({bus.dpi_valid, bus.fifo_full}), 128'({1'b0, 1'b0}));
        end

        // Randomized run against the model.
        do_reset();
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 15;
                    1: pct = 50;
                    default: pct = 90;
                endcase
            end
            r  = $urandom;
            rd = r[11:7];
            f3 = ($urandom_range(0, 3) == 0) ? r[14:12] : 3'd0;
            case ($urandom_range(0, 5))
                0: inst = {r[31:12], rd, 7'h6F};
                1: inst = {r[31:15], f3, rd, 7'h67};
                2: inst = 32'h00008067;
                3: inst = 32'h008000EF;
                4: inst = 32'h00100093;
                default: inst = r;
            endcase
            drive($urandom_range(0, 9) != 0, inst, $urandom, $urandom,
                  $urandom_range(0, 15) != 0, $urandom_range(0, 99) < pct);
            check("random", 128'(got_obs()), 128'(exp_obs()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
